rst_seq_ctrl: RTL and testbench

- Reset sequencer placed downstream of the per-domain reset catch-and-sync cells in the peripheral subsystem.
- Takes the synchronized system reset, watchdog requests and software requests.
- Drives ordered, timed reset release to NUM_DOMAINS dependent reset domains, for example core, bus fabric and peripherals.
- Lower-index domains are released first. A domain reset also resets every domain with a higher index.

---
 rtl/rst_seq_pkg.sv | 15 +
 rtl/rst_seq_timer.sv | 29 ++
 rtl/rst_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
// Holds the sequencer state encoding and the reset-cause codes reported on rst_cause.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    GAP  = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_WDT = 2'd1;
  localparam logic [1:0] CAUSE_SW  = 2'd2;

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable up-counter with synchronous clear and a compare-match against a terminal value.
// A single instance times both the HOLD and GAP phases.
module rst_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] term,
  output logic             match
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign match = (cnt_q == term);

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds dependent domains in reset, then releases them in index order
// with fixed spacing. Watchdog and per-domain software requests restart the sequence.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8,
  localparam int IDX_W      = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   test_mode,
  input  logic                   wdt_rst_req,
  input  logic [NUM_DOMAINS-1:0] sw_rst_req,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   seq_busy,
  output logic [1:0]             rst_cause,
  output logic [IDX_W-1:0]       rst_base,
  output seq_state_e             state_dbg
);

  localparam logic [NUM_DOMAINS-1:0] ALL_ONES = '1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

  seq_state_e             state_q, state_d;
  logic [NUM_DOMAINS-1:0] dr_q, dr_d;
  logic [IDX_W-1:0]       cur_q, cur_d, cur_inc;
  logic [1:0]             cause_q, cause_d;
  logic [IDX_W-1:0]       base_q, base_d;
  logic [IDX_W-1:0]       sw_idx;
  logic                   sw_any;
  logic                   tmr_clr, tmr_en, tmr_match;
  logic [CNT_W-1:0]       tmr_term;

  assign sw_any   = |sw_rst_req;
  assign cur_inc  = cur_q + IDX_W'(1);
  assign tmr_en   = (state_q != RUN);
  assign tmr_term = (state_q == HOLD) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(GAP_CYCLES - 1);

  // Lowest set request bit wins, so scan from the top down.
  always_comb begin
    sw_idx = '0;
    for (int k = NUM_DOMAINS - 1; k >= 0; k--) begin
      if (sw_rst_req[k]) sw_idx = IDX_W'(k);
    end
  end

  always_comb begin
    state_d = state_q;
    dr_d    = dr_q;
    cur_d   = cur_q;
    cause_d = cause_q;
    base_d  = base_q;
    tmr_clr = reset;
    if (wdt_rst_req) begin
      state_d = HOLD;
      dr_d    = ALL_ONES;
      cause_d = CAUSE_WDT;
      base_d  = '0;
      tmr_clr = 1'b1;
    end else if (state_q == RUN && sw_any) begin
      // Domains below the requested index stay released.
      state_d = HOLD;
      dr_d    = ALL_ONES << sw_idx;
      cause_d = CAUSE_SW;
      base_d  = sw_idx;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (tmr_match) begin
            dr_d[base_q] = 1'b0;
            cur_d        = base_q;
            tmr_clr      = 1'b1;
            state_d      = (base_q == LAST_IDX) ? RUN : GAP;
          end
        end
        GAP: begin
          if (tmr_match) begin
            dr_d[cur_inc] = 1'b0;
            cur_d         = cur_inc;
            tmr_clr       = 1'b1;
            if (cur_inc == LAST_IDX) state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= HOLD;
      dr_q    <= ALL_ONES;
      cur_q   <= '0;
      cause_q <= CAUSE_POR;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
      cur_q   <= cur_d;
      cause_q <= cause_d;
      base_q  <= base_d;
    end
  end

  rst_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .clear    (tmr_clr),
    .enable   (tmr_en),
    .load     (1'b0),
    .load_val ('0),
    .term     (tmr_term),
    .match    (tmr_match)
  );

  // Scan bypass drives domain resets straight from the input; the FSM keeps running.
  assign domain_rst = test_mode ? {NUM_DOMAINS{reset}} : dr_q;
  assign seq_busy   = (state_q != RUN);
  assign rst_cause  = cause_q;
  assign rst_base   = base_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl (N=3, HOLD=16, GAP=4) with hand-computed expectations.
// Cycle numbers follow the POR convention: cycle 0 is the first cycle with reset low.
module tb_rst_seq_ctrl;
  import rst_seq_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       test_mode;
  logic       wdt_rst_req;
  logic [2:0] sw_rst_req;
  logic [2:0] domain_rst;
  logic       seq_busy;
  logic [1:0] rst_cause;
  logic [1:0] rst_base;
  seq_state_e state_dbg;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clock = ~clock;

  rst_seq_ctrl #(
    .NUM_DOMAINS (3),
    .HOLD_CYCLES (16),
    .GAP_CYCLES  (4),
    .CNT_W       (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .test_mode   (test_mode),
    .wdt_rst_req (wdt_rst_req),
    .sw_rst_req  (sw_rst_req),
    .domain_rst  (domain_rst),
    .seq_busy    (seq_busy),
    .rst_cause   (rst_cause),
    .rst_base    (rst_base),
    .state_dbg   (state_dbg)
  );

  // Advance to the falling edge inside cycle c.
  task automatic at(input int c);
    repeat (c - cyc) @(posedge clock);
    @(negedge clock);
    cyc = c;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s @cyc %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] dr, input logic busy,
                           input logic [1:0] cause, input logic [1:0] base);
    check({tag, ".dr"},    32'(domain_rst), 32'(dr));
    check({tag, ".busy"},  32'(seq_busy),   32'(busy));
    check({tag, ".cause"}, 32'(rst_cause),  32'(cause));
    check({tag, ".base"},  32'(rst_base),   32'(base));
  endtask

  initial begin
    reset = 1'b1; test_mode = 1'b0; wdt_rst_req = 1'b0; sw_rst_req = 3'b000;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_all("reset", 3'b111, 1'b1, 2'd0, 2'd0);
    check("reset.state", 32'(state_dbg), 32'(HOLD));
    reset = 1'b0;
    cyc = 0;

    // 1: POR release 16/20/24
    at(15); check_all("por15", 3'b111, 1'b1, 2'd0, 2'd0);
    at(16); check_all("por16", 3'b110, 1'b1, 2'd0, 2'd0);
    at(19); check("por19.dr", 32'(domain_rst), 32'(3'b110));
    at(20); check_all("por20", 3'b100, 1'b1, 2'd0, 2'd0);
    at(23); check_all("por23", 3'b100, 1'b1, 2'd0, 2'd0);
    at(24); check_all("por24", 3'b000, 1'b0, 2'd0, 2'd0);
    check("por24.state", 32'(state_dbg), 32'(RUN));

    // 2: watchdog pulse at 40, releases 57/61/65
    at(40); wdt_rst_req = 1'b1;
    at(41); wdt_rst_req = 1'b0; check_all("wdt41", 3'b111, 1'b1, 2'd1, 2'd0);
    at(56); check("wdt56.dr", 32'(domain_rst), 32'(3'b111));
    at(57); check("wdt57.dr", 32'(domain_rst), 32'(3'b110));
    at(61); check("wdt61.dr", 32'(domain_rst), 32'(3'b100));
    at(64); check_all("wdt64", 3'b100, 1'b1, 2'd1, 2'd0);
    at(65); check_all("wdt65", 3'b000, 1'b0, 2'd1, 2'd0);

    // 3: software reset of domains 1..2 at t=80
    at(80); sw_rst_req = 3'b010;
    at(81); sw_rst_req = 3'b000; check_all("sw81", 3'b110, 1'b1, 2'd2, 2'd1);
    at(96); check("sw96.dr", 32'(domain_rst), 32'(3'b110));
    at(97); check("sw97.dr", 32'(domain_rst), 32'(3'b100));
    at(100); check("sw100.dr", 32'(domain_rst), 32'(3'b100));
    at(101); check_all("sw101", 3'b000, 1'b0, 2'd2, 2'd1);

    // 4a: coincident wdt and sw in RUN, wdt wins
    at(120); sw_rst_req = 3'b110; wdt_rst_req = 1'b1;
    at(121); sw_rst_req = 3'b000; wdt_rst_req = 1'b0;
    check_all("coin121", 3'b111, 1'b1, 2'd1, 2'd0);
    at(137); check("coin137.dr", 32'(domain_rst), 32'(3'b110));
    // 4b: sw request during GAP is dropped
    at(139); sw_rst_req = 3'b001;
    at(140); sw_rst_req = 3'b000; check("gap140.dr", 32'(domain_rst), 32'(3'b110));
    at(141); check("gap141.dr", 32'(domain_rst), 32'(3'b100));
    at(144); check_all("gap144", 3'b100, 1'b1, 2'd1, 2'd0);
    at(145); check_all("gap145", 3'b000, 1'b0, 2'd1, 2'd0);

    // 5: new POR (cycle 0 = 161), watchdog at POR cycle 18
    at(160); reset = 1'b1;
    at(161); reset = 1'b0; check_all("por2_0", 3'b111, 1'b1, 2'd0, 2'd0);
    at(177); check("por2_16.dr", 32'(domain_rst), 32'(3'b110));
    at(179); check("por2_18.dr", 32'(domain_rst), 32'(3'b110)); wdt_rst_req = 1'b1;
    at(180); wdt_rst_req = 1'b0; check_all("por2_19", 3'b111, 1'b1, 2'd1, 2'd0);
    at(195); check("por2_34.dr", 32'(domain_rst), 32'(3'b111));
    at(196); check("por2_35.dr", 32'(domain_rst), 32'(3'b110));
    at(200); check("por2_39.dr", 32'(domain_rst), 32'(3'b100));
    at(204); check_all("por2_43", 3'b000, 1'b0, 2'd1, 2'd0);

    // 6: test_mode bypass; reset sampled at edge ending 221, so cycle 0 = 222
    at(220); test_mode = 1'b1; #1;
    check("tm220.dr", 32'(domain_rst), 32'(3'b000));
    at(221); reset = 1'b1; #1;
    check("tm221.dr", 32'(domain_rst), 32'(3'b111));
    at(222); reset = 1'b0; #1;
    check("tm222.dr", 32'(domain_rst), 32'(3'b000));
    check_all("tm222", 3'b000, 1'b1, 2'd0, 2'd0);
    at(245); check_all("tm245", 3'b000, 1'b1, 2'd0, 2'd0);
    at(246); check_all("tm246", 3'b000, 1'b0, 2'd0, 2'd0);
    test_mode = 1'b0; #1;
    check("tm_off.dr", 32'(domain_rst), 32'(3'b000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
